// File: rtl/period_to_freq_pkg.sv
// rtl/period_to_freq_pkg.sv - shared states, default constants and BCD helper for period_to_freq
package period_to_freq_pkg;

    localparam int CLK_HZ_DEF = 50_000_000;
    localparam int PW_DEF     = 16;
    localparam int QW_DEF     = 26;
    localparam int BCD_DIGITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_BCD,
        ST_DONE
    } state_t;

    // Double-dabble pre-shift correction: every digit of 5 or more gets +3.
    function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] v);
        logic [4*BCD_DIGITS-1:0] r;
        r = v;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/period_to_freq_seq_divider.sv
// rtl/period_to_freq_seq_divider.sv - restoring shift-subtract divider, one quotient bit per cycle
module seq_divider #(
    parameter int DW = 26,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    input  logic [DW-1:0] i_dividend,
    input  logic [VW-1:0] i_divisor,
    output logic          o_done,
    output logic [DW-1:0] o_quotient
);

    localparam int CW = $clog2(DW);

    logic [VW:0]   r_rem;
    logic [DW-1:0] r_quo;
    logic [VW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic          r_run;

    logic [VW:0]   w_trial;
    logic [VW+1:0] w_sub;
    logic          w_ge;

    // Remainder stays below the divisor, so dropping its top bit on the shift loses nothing.
    assign w_trial    = (VW+1)'({r_rem, r_quo[DW-1]});
    assign w_sub      = {1'b0, w_trial} - {2'b00, r_div};
    assign w_ge       = ~w_sub[VW+1];
    assign o_done     = r_run && (r_cnt == CW'(DW-1));
    assign o_quotient = r_quo;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_div <= i_divisor;
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run) begin
            r_rem <= w_ge ? w_sub[VW:0] : w_trial;
            r_quo <= {r_quo[DW-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/period_to_freq.sv
// rtl/period_to_freq.sv - period count to Hz converter; FREQ_BCD_EN adds packed BCD output
module period_to_freq
    import period_to_freq_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEF,
    parameter int PW     = PW_DEF,
    parameter int QW     = QW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PW-1:0] period_in,
    input  logic          period_valid,
    output logic          busy,
    output logic [QW-1:0] freq_out,
    output logic          freq_valid,
    output logic          div_zero,
    output logic          overrun
`ifdef FREQ_BCD_EN
    ,
    output logic [4*BCD_DIGITS-1:0] bcd_out
`endif
);

    state_t        r_state;
    state_t        w_next;
    logic          r_busy;
    logic [QW-1:0] r_freq;
    logic          r_freq_valid;
    logic          r_div_zero;
    logic          r_overrun;

    logic          w_accept;
    logic          w_div_start;
    logic          w_div_done;
    logic [QW-1:0] w_quotient;

    assign w_accept    = (r_state == ST_IDLE) && period_valid;
    assign w_div_start = w_accept && (period_in != '0);

    seq_divider #(
        .DW(QW),
        .VW(PW)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (QW'(CLK_HZ)),
        .i_divisor  (period_in),
        .o_done     (w_div_done),
        .o_quotient (w_quotient)
    );

`ifdef FREQ_BCD_EN
    localparam int CW = $clog2(QW);

    logic [CW-1:0]           r_bcd_cnt;
    logic [4*BCD_DIGITS-1:0] r_bcd;
    logic [4*BCD_DIGITS-1:0] r_bcd_out;
    logic [4*BCD_DIGITS-1:0] w_bcd_adj;
    logic [CW-1:0]           w_bit_idx;

    // Quotient bits are consumed MSB first straight from the divider's held result.
    assign w_bcd_adj = bcd_adjust(r_bcd);
    assign w_bit_idx = CW'(QW-1) - r_bcd_cnt;
    assign bcd_out   = r_bcd_out;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (period_valid) begin
                    w_next = (period_in == '0) ? ST_DONE : ST_DIV;
                end
            end
            ST_DIV: begin
                if (w_div_done) begin
`ifdef FREQ_BCD_EN
                    w_next = ST_BCD;
`else
                    w_next = ST_DONE;
`endif
                end
            end
            ST_BCD: begin
`ifdef FREQ_BCD_EN
                if (r_bcd_cnt == CW'(QW-1)) begin
                    w_next = ST_DONE;
                end
`else
                w_next = ST_IDLE;
`endif
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_freq       <= '0;
            r_freq_valid <= 1'b0;
            r_div_zero   <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef FREQ_BCD_EN
            r_bcd_cnt    <= '0;
            r_bcd        <= '0;
            r_bcd_out    <= '0;
`endif
        end else begin
            r_state      <= w_next;
            r_freq_valid <= 1'b0;
            if (period_valid && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            if (w_accept) begin
                r_busy     <= 1'b1;
                r_div_zero <= (period_in == '0);
            end
`ifdef FREQ_BCD_EN
            if ((r_state == ST_DIV) && w_div_done) begin
                r_bcd_cnt <= '0;
                r_bcd     <= '0;
            end else if (r_state == ST_BCD) begin
                r_bcd     <= (4*BCD_DIGITS)'({w_bcd_adj, w_quotient[w_bit_idx]});
                r_bcd_cnt <= r_bcd_cnt + 1'b1;
            end
`endif
            if (r_state == ST_DONE) begin
                r_freq       <= r_div_zero ? '0 : w_quotient;
                r_freq_valid <= 1'b1;
                r_busy       <= 1'b0;
`ifdef FREQ_BCD_EN
                r_bcd_out    <= r_div_zero ? '0 : r_bcd;
`endif
            end
        end
    end

    assign busy       = r_busy;
    assign freq_out   = r_freq;
    assign freq_valid = r_freq_valid;
    assign div_zero   = r_div_zero;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_period_to_freq.sv
// tb/tb_period_to_freq.sv - self-checking bench for period_to_freq against a cycle-level model
module tb_period_to_freq;

    localparam int CLK_HZ = 50_000_000;
`ifdef FREQ_BCD_EN
    localparam int LAT     = 2*26 + 2;
    localparam int EXP_LAT = 53;
`else
    localparam int LAT     = 26 + 2;
    localparam int EXP_LAT = 27;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] period_in = '0;
    logic        period_valid = 1'b0;
    logic        busy;
    logic [25:0] freq_out;
    logic        freq_valid;
    logic        div_zero;
    logic        overrun;
`ifdef FREQ_BCD_EN
    logic [31:0] bcd_out;
`endif

    int tests  = 0;
    int fails  = 0;
    int cyc    = 0;

    period_to_freq dut (
        .clk          (clk),
        .rst          (rst),
        .period_in    (period_in),
        .period_valid (period_valid),
        .busy         (busy),
        .freq_out     (freq_out),
        .freq_valid   (freq_valid),
        .div_zero     (div_zero),
        .overrun      (overrun)
`ifdef FREQ_BCD_EN
        ,
        .bcd_out      (bcd_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Model: a conversion accepted at edge e completes (freq_valid) at edge e+LAT-1, or e+1 for period 0.
    int          m_done = -1000;
    int          m_pend = 0;
    int          m_freq = 0;
    logic [31:0] m_bcd  = '0;
    bit          m_dz   = 1'b0;
    bit          m_ovr  = 1'b0;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_done = -1000;
            m_freq = 0;
            m_bcd  = '0;
            m_dz   = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            if (period_valid) begin
                if (cyc > m_done) begin
                    m_dz   = (period_in == 0);
                    m_pend = (period_in == 0) ? 0 : CLK_HZ / int'(period_in);
                    m_done = cyc + ((period_in == 0) ? 1 : LAT - 1);
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (cyc == m_done) begin
                m_freq = m_pend;
                m_bcd  = to_bcd(m_pend);
            end
        end
    end

    always @(negedge clk) begin
        if (cyc >= 1) begin
            check("busy",       busy,       (cyc < m_done));
            check("freq_valid", freq_valid, (cyc == m_done));
            check("freq_out",   freq_out,   m_freq);
            check("div_zero",   div_zero,   m_dz);
            check("overrun",    overrun,    m_ovr);
`ifdef FREQ_BCD_EN
            check("bcd_out",    bcd_out,    m_bcd);
`endif
        end
    end

    // Called at a negedge; returns at the next negedge with s = edge that sampled the strobe.
    task automatic pulse(input logic [15:0] p, output int s);
        period_in    = p;
        period_valid = 1'b1;
        @(negedge clk);
        period_valid = 1'b0;
        s = cyc;
    endtask

    task automatic wait_valid(input string name, input int base, input int exp_f, input int exp_lat);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (freq_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_seen"}, seen, 1'b1);
        if (seen) begin
            check({name, "_lat"},  cyc - base, exp_lat);
            check({name, "_freq"}, freq_out, exp_f);
            @(negedge clk);
            check({name, "_one_cycle"}, freq_valid, 1'b0);
        end
    endtask

    initial begin
        int s, s2, nvalid, first_f;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 1'b0);
        check("rst_freq", freq_out, 0);
        check("rst_fv",   freq_valid, 1'b0);
        check("rst_ovr",  overrun, 1'b0);

        pulse(16'd50000, s);
        check("busy_early", busy, 1'b1);
        wait_valid("p50000", s, 1000, EXP_LAT);
        check("p50000_dz", div_zero, 1'b0);
`ifdef FREQ_BCD_EN
        check("p50000_bcd", bcd_out, 32'h0000_1000);
`endif
        pulse(16'd1, s);
        wait_valid("p1", s, 50_000_000, EXP_LAT);
        pulse(16'd3, s);
        wait_valid("p3", s, 16_666_666, EXP_LAT);

        pulse(16'd0, s);
        wait_valid("p0", s, 0, 1);
        check("p0_dz", div_zero, 1'b1);
        pulse(16'd2, s);
        wait_valid("p2", s, 25_000_000, EXP_LAT);
        check("p2_dz", div_zero, 1'b0);

        pulse(16'd60000, s);
        repeat (4) @(negedge clk);
        pulse(16'd7, s2);
        check("ovr_set", overrun, 1'b1);
        wait_valid("p60000", s, 833, EXP_LAT);
        repeat (10) @(negedge clk);
        check("ovr_sticky", overrun, 1'b1);

        pulse(16'd100, s);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_freq", freq_out, 0);
        check("abort_ovr",  overrun, 1'b0);
        nvalid = 0;
        repeat (60) begin
            @(negedge clk);
            if (freq_valid) nvalid++;
        end
        check("abort_no_valid", nvalid, 0);
        pulse(16'd100, s);
        wait_valid("p100", s, 500_000, EXP_LAT);

        pulse(16'd4, s);
        first_f = -1;
        repeat (LAT) begin
            @(negedge clk);
            if (freq_valid) first_f = int'(freq_out);
        end
        check("b2b_first", first_f, 12_500_000);
        pulse(16'd5, s2);
        check("b2b_spacing", s2 - s, LAT + 1);
        wait_valid("b2b_second", s2, 10_000_000, EXP_LAT);
        check("b2b_ovr", overrun, 1'b0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/period_to_freq.md
# period_to_freq

Converts the 16-bit clock-cycle period count produced by the pulse-measurement stage into a frequency in Hz (CLK_HZ / period) using a sequential shift-subtract divider. Optionally converts the result to packed BCD for the seven-segment display stage. Sits directly downstream of the pulse-measurement block, between it and the display driver.

## Interface
- CLK_HZ, 50_000_000, system clock frequency in Hz; must be < 100_000_000.
- PW, 16, period input width.
- QW, 26, quotient width; must satisfy 2^QW > CLK_HZ.
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- period_in  input  PW  measured period in clk cycles.
- period_valid  input  1  one-cycle strobe; upstream asserts it in the cycle period_in is updated.
- busy  output  1  high while a conversion is in progress.
- freq_out  output  QW  last computed frequency, Hz, truncated.
- freq_valid  output  1  one-cycle strobe; all result outputs are valid and stable.
- div_zero  output  1  last accepted period was 0.
- overrun  output  1  sticky; a strobe arrived while busy.
- bcd_out  output  32  8 packed BCD digits of freq_out, digit 0 in [3:0]. Present only with FREQ_BCD_EN.

## Operation
- Reset values: busy=0, freq_out=0, freq_valid=0, div_zero=0, overrun=0, bcd_out=0, FSM in IDLE.
- States: IDLE, DIV, BCD (with macro only), DONE.
- IDLE: on period_valid, latch period_in, busy=1.
  - Period 0: div_zero=1, freq_out=0, bcd_out=0, go to DONE.
  - Otherwise: div_zero=0, load dividend=CLK_HZ and remainder=0, go to DIV.
- DIV: restoring division, one quotient bit per cycle, MSB first, QW iterations. Remainder width PW+1. Quotient is truncated and the remainder is discarded.
- BCD: double-dabble over the QW quotient bits, one shift per cycle, QW cycles. Add 3 to each digit ≥5 before each shift.
- DONE: register freq_out (and bcd_out); pulse freq_valid for one cycle; busy=0; return to IDLE.
- period_valid while busy: ignored, overrun=1. Only rst clears overrun.
- period_valid in the same cycle as the DONE strobe: ignored, overrun=1. The block accepts new strobes only in IDLE.
- freq_out and bcd_out hold their previous values until the DONE cycle. They never show partial results.

## Timing
- The strobe is sampled at edge 0, and busy is high from edge 0.
- Without macro: freq_valid high in the cycle after edge QW+1 (QW+2 cycles of latency). busy drops in the same edge.
- With macro: freq_valid after edge 2·QW+1.
- Period 0: freq_valid after edge 1.
- Minimum strobe spacing for no overrun: latency + 1 cycle.
- rst mid-conversion: abort, return all outputs to reset values, no freq_valid.

## Configuration
- FREQ_BCD_EN defined: the BCD state and the bcd_out port are compiled in. Latency is 2·QW+2.
- FREQ_BCD_EN undefined: no BCD logic and no bcd_out port. DIV goes directly to DONE. Latency is QW+2.

## Structure
- Shared package holds:
  - the FSM state enum (IDLE, DIV, BCD, DONE);
  - default constants CLK_HZ_DEF, PW_DEF, QW_DEF;
  - BCD_DIGITS = 8.
- One sub-module: seq_divider. It performs the QW-cycle shift-subtract division with start/done handshake and parameters for dividend and divisor widths. The top FSM sequences it and holds the BCD logic.

## Test plan
- Period 50000, CLK_HZ 50M → freq_out 1000, div_zero 0, bcd_out 0x00001000, freq_valid exactly one cycle at the specified latency.
- Period 1 → freq_out 50_000_000. Period 3 → freq_out 16_666_666 (truncation).
- Period 0 → div_zero 1, freq_out 0, freq_valid after edge 1. Then period 2 → div_zero 0, freq_out 25_000_000.
- Second strobe 5 cycles after the first → overrun 1. The result corresponds only to the first period. Only rst clears overrun.
- rst asserted at DIV iteration 10 → all outputs at reset values, no freq_valid. A new strobe afterwards converts correctly.
- Back-to-back strobes spaced exactly latency+1 cycles apart → both accepted, overrun stays 0.
